// File: rtl/ceespu_execute_mc.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier / restoring divider.
// Optional macro CEESPU_EXEC_DIV_EN adds DIVU/REMU to the iterative unit; without it those ops return 0.
module ceespu_execute_mc #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PCW  = 14
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_valid,
  input  logic [XLEN-1:0]   I_dataA,
  input  logic [XLEN-1:0]   I_dataB,
  input  logic [XLEN-1:0]   I_storeData,
  input  logic [3:0]        I_aluop,
  input  logic [1:0]        I_selCin,
  input  logic [2:0]        I_selMem,
  input  logic [4:0]        I_regD,
  input  logic [PCW-1:0]    I_PC,
  input  logic              I_we,
  input  logic              I_memE,
  input  logic              I_memWe,
  output logic              O_busy,
  output logic [XLEN-1:0]   O_memAddress,
  output logic [XLEN-1:0]   O_storeData,
  output logic [XLEN/8-1:0] O_memWe,
  output logic              O_valid,
  output logic [XLEN-1:0]   O_result,
  output logic              O_we,
  output logic [4:0]        O_regD,
  output logic [PCW-1:0]    O_PC,
  output logic [2:0]        O_selMem,
  output logic              O_carry
);

  localparam int unsigned SW  = $clog2(XLEN);
  localparam int unsigned NB  = XLEN / 8;
  localparam int unsigned LW  = $clog2(NB);
  localparam int unsigned XW1 = XLEN + 1;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_MULHU = 4'd9;
  localparam logic [3:0] OP_DIVU  = 4'd10;
  localparam logic [3:0] OP_REMU  = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [3:0]        op_q, op_d;
  logic              pwe_q, pwe_d;
  logic [4:0]        prd_q, prd_d;
  logic [PCW-1:0]    ppc_q, ppc_d;
  logic [2:0]        psel_q, psel_d;

  logic              valid_q, valid_d, we_q, we_d, carry_q, carry_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        regd_q, regd_d;
  logic [PCW-1:0]    pc_q, pc_d;
  logic [2:0]        sel_q, sel_d;

  logic              cin;
  logic [XLEN-1:0]   b_op;
  logic [XLEN:0]     alu_sum;
  logic [XLEN-1:0]   alu_res;
  logic [SW-1:0]     shamt;
  logic              is_mc;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi, mul_lo;
  logic              mem_en;
  logic [LW-1:0]     addr_lane;

  // Carry-in source; O_carry only moves on accepted ADD/SUB
  always_comb begin
    cin = 1'b0;
    case (I_selCin)
      2'd1:    cin = carry_q;
      2'd2:    cin = ~carry_q;
      2'd3:    cin = 1'b1;
      default: cin = 1'b0;
    endcase
  end

  assign b_op         = (I_aluop == OP_SUB) ? ~I_dataB : I_dataB;
  assign alu_sum      = {1'b0, I_dataA} + {1'b0, b_op} + XW1'(cin);
  assign O_memAddress = I_dataA + I_dataB + XLEN'(cin);
  assign shamt        = I_dataB[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (I_aluop)
      OP_ADD, OP_SUB: alu_res = alu_sum[XLEN-1:0];
      OP_AND:         alu_res = I_dataA & I_dataB;
      OP_OR:          alu_res = I_dataA | I_dataB;
      OP_XOR:         alu_res = I_dataA ^ I_dataB;
      OP_SLL:         alu_res = I_dataA << shamt;
      OP_SRL:         alu_res = I_dataA >> shamt;
      OP_SRA:         alu_res = $signed(I_dataA) >>> shamt;
      default:        alu_res = '0;
    endcase
  end

`ifdef CEESPU_EXEC_DIV_EN
  logic            div_in, div_run;
  logic [XLEN:0]   r_shift;
  logic [XLEN+1:0] r_diff;
  logic [XLEN-1:0] div_hi, div_lo;

  assign div_in  = (I_aluop == OP_DIVU) || (I_aluop == OP_REMU);
  assign div_run = (op_q == OP_DIVU) || (op_q == OP_REMU);
  assign is_mc   = (I_aluop == OP_MUL) || (I_aluop == OP_MULHU) || div_in;

  // Restoring step: hi holds the partial remainder, lo shifts dividend out and quotient in
  assign r_shift = {hi_q, lo_q[XLEN-1]};
  assign r_diff  = {1'b0, r_shift} - {2'b00, m_q};
  assign div_hi  = r_diff[XLEN+1] ? XLEN'(r_shift) : XLEN'(r_diff);
  assign div_lo  = {lo_q[XLEN-2:0], ~r_diff[XLEN+1]};
`else
  assign is_mc   = (I_aluop == OP_MUL) || (I_aluop == OP_MULHU);
`endif

  // Shift-add step on the {hi,lo} product register, multiplier consumed from lo[0]
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
  assign mul_hi  = mul_sum[XLEN:1];
  assign mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};

  assign O_busy = ~I_rst & (((state_q == S_IDLE) & I_valid & is_mc) | (state_q == S_RUN));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    op_d     = op_q;
    pwe_d    = pwe_q;
    prd_d    = prd_q;
    ppc_d    = ppc_q;
    psel_d   = psel_q;
    valid_d  = 1'b0;
    we_d     = 1'b0;
    result_d = result_q;
    regd_d   = regd_q;
    pc_d     = pc_q;
    sel_d    = sel_q;
    carry_d  = carry_q;
    case (state_q)
      S_IDLE: begin
        if (I_valid && is_mc) begin
          state_d = S_RUN;
          cnt_d   = '0;
          op_d    = I_aluop;
          hi_d    = '0;
          m_d     = I_dataA;
          lo_d    = I_dataB;
`ifdef CEESPU_EXEC_DIV_EN
          if (div_in) begin
            m_d  = I_dataB;
            lo_d = I_dataA;
          end
`endif
          pwe_d   = I_we;
          prd_d   = I_regD;
          ppc_d   = I_PC;
          psel_d  = I_selMem;
        end else if (I_valid) begin
          valid_d  = 1'b1;
          we_d     = I_we;
          result_d = alu_res;
          regd_d   = I_regD;
          pc_d     = I_PC;
          sel_d    = I_selMem;
          if ((I_aluop == OP_ADD) || (I_aluop == OP_SUB)) carry_d = alu_sum[XLEN];
        end
      end
      S_RUN: begin
        hi_d = mul_hi;
        lo_d = mul_lo;
`ifdef CEESPU_EXEC_DIV_EN
        if (div_run) begin
          hi_d = div_hi;
          lo_d = div_lo;
        end
`endif
        cnt_d = cnt_q + SW'(1);
        if (cnt_q == SW'(XLEN - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d  = S_IDLE;
        valid_d  = 1'b1;
        we_d     = pwe_q;
        result_d = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? hi_q : lo_q;
        regd_d   = prd_q;
        pc_d     = ppc_q;
        sel_d    = psel_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      op_q     <= '0;
      pwe_q    <= 1'b0;
      prd_q    <= '0;
      ppc_q    <= '0;
      psel_q   <= '0;
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      result_q <= '0;
      regd_q   <= '0;
      pc_q     <= '0;
      sel_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      op_q     <= op_d;
      pwe_q    <= pwe_d;
      prd_q    <= prd_d;
      ppc_q    <= ppc_d;
      psel_q   <= psel_d;
      valid_q  <= valid_d;
      we_q     <= we_d;
      result_q <= result_d;
      regd_q   <= regd_d;
      pc_q     <= pc_d;
      sel_q    <= sel_d;
      carry_q  <= carry_d;
    end
  end

  assign O_valid  = valid_q;
  assign O_we     = we_q;
  assign O_result = result_q;
  assign O_regD   = regd_q;
  assign O_PC     = pc_q;
  assign O_selMem = sel_q;
  assign O_carry  = carry_q;

  // Store lane replication and byte enables
  assign mem_en    = I_valid & I_memE & I_memWe & ~O_busy;
  assign addr_lane = O_memAddress[LW-1:0];

  always_comb begin
    O_storeData = I_storeData;
    O_memWe     = '0;
    for (int i = 0; i < int'(NB); i++) begin
      case (I_selMem[1:0])
        2'd2: begin
          O_storeData[8*i +: 8] = I_storeData[7:0];
          O_memWe[i]            = mem_en & (addr_lane == LW'(i));
        end
        2'd1: begin
          O_storeData[8*i +: 8] = I_storeData[8*(i%2) +: 8];
          O_memWe[i]            = mem_en & ((addr_lane >> 1) == (LW'(i) >> 1));
        end
        default: O_memWe[i] = mem_en;
      endcase
    end
  end

endmodule
